// File: rtl/soc_msp430_ram_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_msp430_ram_mover_pkg
//  Description : Shared types and constants for the RAM block-move engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_msp430_ram_mover_pkg;

   // Engine sequencing states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Transfer modes as presented on the mode input
   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   // Full-word byte-enable pattern used for every engine write
   localparam logic [1:0] RAM_WE_WORD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/soc_msp430_ram_mover.sv
`default_nettype none
// ============================================================================
//  Module      : soc_msp430_ram_mover
//  Description : Block copy / fill engine driving one port of the dual-port
//                data-memory RAM. Copies take RD/CAP/WR per word, fills take
//                one WR per word. The arbiter hold input stalls RAM accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef DMEM_MSB
`define DMEM_MSB 8
`endif

module soc_msp430_ram_mover
   import soc_msp430_ram_mover_pkg::*;
#(
   parameter int ADDR_W = `DMEM_MSB,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              mclk,
   input  logic              puc_rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic [15:0]       fill_val,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              ram_en,
   output logic [1:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout
);

   state_t              r_state;
   logic                r_mode;
   logic [ADDR_W-1:0]   r_src;
   logic [ADDR_W-1:0]   r_dst;
   logic [LEN_W-1:0]    r_cnt;
   logic [15:0]         r_fill;
   logic [15:0]         r_data;

   // Sequencer plus datapath registers; hold freezes everything in RD/WR only
   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_COPY;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_fill  <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_mode <= mode;
                  r_src  <= src_addr;
                  r_dst  <= dst_addr;
                  r_cnt  <= len;
                  r_fill <= fill_val;
                  if (len == '0)
                     r_state <= ST_DONE;
                  else if (mode == MODE_FILL)
                     r_state <= ST_WR;
                  else
                     r_state <= ST_RD;
               end
            end
            ST_RD: begin
               if (!hold)
                  r_state <= ST_CAP;
            end
            ST_CAP: begin
               // Read data is valid this cycle; CAP never stalls
               r_data  <= ram_dout;
               r_state <= ST_WR;
            end
            ST_WR: begin
               if (!hold) begin
                  r_src <= r_src + ADDR_W'(1);
                  r_dst <= r_dst + ADDR_W'(1);
                  r_cnt <= r_cnt - LEN_W'(1);
                  if (r_cnt == LEN_W'(1))
                     r_state <= ST_DONE;
                  else if (r_mode == MODE_FILL)
                     r_state <= ST_WR;
                  else
                     r_state <= ST_RD;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM port and status decode from the registered state; hold masks en/we
   always_comb begin
      busy     = (r_state != ST_IDLE);
      done     = (r_state == ST_DONE);
      ram_en   = 1'b0;
      ram_we   = 2'b00;
      ram_addr = '0;
      ram_din  = '0;
      case (r_state)
         ST_RD: begin
            ram_en   = ~hold;
            ram_addr = r_src;
         end
         ST_WR: begin
            ram_en   = ~hold;
            ram_we   = hold ? 2'b00 : RAM_WE_WORD;
            ram_addr = r_dst;
            ram_din  = (r_mode == MODE_FILL) ? r_fill : r_data;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire
